// File: rtl/phy_rx_hdr_parse.sv
// 802.11 MAC header parser on the RX byte stream (one byte per beat).
// Byte 1 decodes the frame control word and fixes the header layout. After that, each field
// is committed from a 48-bit byte shift register on the field's last byte.
//
// state | meaning
// IDLE  | waiting for a byte at index 0
// PARSE | collecting header bytes in index order
// DONE  | header complete, ignore bytes until the next index 0
// SKIP  | header rejected, ignore bytes until the next index 0
module phy_rx_hdr_parse #(
  parameter int unsigned IDX_W    = 16,
  parameter bit          ADDR4_EN = 1'b1,
  parameter bit          QOS_EN   = 1'b1,
  parameter bit          HTC_EN   = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] byte_index,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  input  logic             frame_abort,
  output logic [15:0]      fc,
  output logic [15:0]      dur_id,
  output logic [15:0]      sc,
  output logic [15:0]      qos,
  output logic [47:0]      addr1,
  output logic [47:0]      addr2,
  output logic [47:0]      addr3,
  output logic [47:0]      addr4,
  output logic [31:0]      htc,
  output logic             fc_valid,
  output logic             dur_id_valid,
  output logic             addr1_valid,
  output logic             addr2_valid,
  output logic             addr3_valid,
  output logic             addr4_valid,
  output logic             sc_valid,
  output logic             qos_valid,
  output logic             htc_valid,
  output logic             has_addr2,
  output logic             has_addr3,
  output logic             has_addr4,
  output logic             has_qos,
  output logic             has_htc,
  output logic [5:0]       hdr_len,
  output logic             hdr_done,
  output logic             hdr_err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {IDLE, PARSE, DONE, SKIP} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, hlen, pos_qos, pos_htc, l_len;
  logic [47:0] sh, sh_in;
  logic [15:0] fc_new;
  logic        take, restart, idx_match, in_seq;
  logic        l_a2, l_a3, l_a4, l_qos, l_htc, l_rsvd;
  logic        done_nxt, err_nxt;
  logic [1:0]  code_nxt;

  assign sh_in     = {byte_data, sh[47:8]};
  assign fc_new    = sh_in[47:32];
  assign take      = byte_valid & ~frame_abort;
  assign restart   = take & (byte_index == '0);
  assign idx_match = (byte_index == IDX_W'(cnt));
  assign in_seq    = take & (state == PARSE) & ~restart & idx_match;
  // QoS follows Addr4 when present; HT Control follows QoS when present
  assign pos_qos   = has_addr4 ? 6'd30 : 6'd24;
  assign pos_htc   = pos_qos + (has_qos ? 6'd2 : 6'd0);

  // Header layout implied by the frame control word being completed this beat
  always_comb begin
    l_a2   = 1'b0;
    l_a3   = 1'b0;
    l_a4   = 1'b0;
    l_qos  = 1'b0;
    l_htc  = 1'b0;
    l_rsvd = 1'b0;
    l_len  = 6'd0;
    unique case (fc_new[3:2])
      2'b00: begin
        l_a2  = 1'b1;
        l_a3  = 1'b1;
        l_htc = HTC_EN & fc_new[15];
        l_len = l_htc ? 6'd28 : 6'd24;
      end
      2'b01: begin
        if (fc_new[7:4] == 4'b1100 || fc_new[7:4] == 4'b1101) begin
          l_len = 6'd10;
        end else begin
          l_a2  = 1'b1;
          l_len = 6'd16;
        end
      end
      2'b10: begin
        l_a2  = 1'b1;
        l_a3  = 1'b1;
        l_a4  = ADDR4_EN & fc_new[8] & fc_new[9];
        l_qos = QOS_EN & fc_new[7];
        l_htc = HTC_EN & fc_new[7] & fc_new[15];
        l_len = 6'd24 + (l_a4 ? 6'd6 : 6'd0) + (l_qos ? 6'd2 : 6'd0) + (l_htc ? 6'd4 : 6'd0);
      end
      default: l_rsvd = 1'b1;
    endcase
  end

  // Next state plus done/error strobes; abort has priority over any byte
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = 2'd0;
    if (frame_abort) begin
      state_nxt = IDLE;
      if (state == PARSE) begin
        err_nxt  = 1'b1;
        code_nxt = 2'd3;
      end
    end else if (restart) begin
      state_nxt = PARSE;
    end else if (byte_valid && state == PARSE) begin
      if (!idx_match) begin
        err_nxt   = 1'b1;
        code_nxt  = 2'd2;
        state_nxt = SKIP;
      end else if (cnt == 6'd1 && l_rsvd) begin
        err_nxt   = 1'b1;
        code_nxt  = 2'd1;
        state_nxt = SKIP;
      end else if (cnt == hlen - 6'd1) begin
        done_nxt  = 1'b1;
        state_nxt = DONE;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Byte capture, field commit and per-field pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0; hlen <= '0; sh <= '0;
      fc <= '0; dur_id <= '0; sc <= '0; qos <= '0; htc <= '0;
      addr1 <= '0; addr2 <= '0; addr3 <= '0; addr4 <= '0;
      fc_valid <= 1'b0; dur_id_valid <= 1'b0; sc_valid <= 1'b0; qos_valid <= 1'b0;
      htc_valid <= 1'b0; addr1_valid <= 1'b0; addr2_valid <= 1'b0;
      addr3_valid <= 1'b0; addr4_valid <= 1'b0;
      has_addr2 <= 1'b0; has_addr3 <= 1'b0; has_addr4 <= 1'b0;
      has_qos <= 1'b0; has_htc <= 1'b0;
      hdr_len <= '0; hdr_done <= 1'b0; hdr_err <= 1'b0; err_code <= '0;
    end else begin
      fc_valid <= 1'b0; dur_id_valid <= 1'b0; sc_valid <= 1'b0; qos_valid <= 1'b0;
      htc_valid <= 1'b0; addr1_valid <= 1'b0; addr2_valid <= 1'b0;
      addr3_valid <= 1'b0; addr4_valid <= 1'b0;
      hdr_done <= done_nxt;
      hdr_err  <= err_nxt;
      if (err_nxt) err_code <= code_nxt;
      if (restart) begin
        cnt <= 6'd1; hlen <= '0; hdr_len <= '0; sh <= sh_in;
        has_addr2 <= 1'b0; has_addr3 <= 1'b0; has_addr4 <= 1'b0;
        has_qos <= 1'b0; has_htc <= 1'b0;
      end else if (in_seq) begin
        cnt <= cnt + 6'd1;
        sh  <= sh_in;
        if (cnt == 6'd1) begin
          fc <= fc_new; fc_valid <= 1'b1; hlen <= l_len;
          has_addr2 <= l_a2; has_addr3 <= l_a3; has_addr4 <= l_a4;
          has_qos <= l_qos; has_htc <= l_htc;
        end
        if (cnt == 6'd3)               begin dur_id <= sh_in[47:32]; dur_id_valid <= 1'b1; end
        if (cnt == 6'd9)               begin addr1 <= sh_in; addr1_valid <= 1'b1; end
        if (cnt == 6'd15 && has_addr2) begin addr2 <= sh_in; addr2_valid <= 1'b1; end
        if (cnt == 6'd21 && has_addr3) begin addr3 <= sh_in; addr3_valid <= 1'b1; end
        if (cnt == 6'd23)              begin sc <= sh_in[47:32]; sc_valid <= 1'b1; end
        if (cnt == 6'd29 && has_addr4) begin addr4 <= sh_in; addr4_valid <= 1'b1; end
        if (cnt == pos_qos + 6'd1 && has_qos) begin qos <= sh_in[47:32]; qos_valid <= 1'b1; end
        if (cnt == pos_htc + 6'd3 && has_htc) begin htc <= sh_in[47:16]; htc_valid <= 1'b1; end
        if (done_nxt) hdr_len <= hlen;
      end
    end
  end

endmodule
